// File: rtl/rice_core_bus_arbiter_pkg.sv
// Shared types for the core bus arbiter: FSM state encoding and the one-hot bus owner.
package rice_core_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQUEST  = 2'd1,
    ST_RESPONSE = 2'd2
  } rice_core_bus_arbiter_state;

  // One-hot owner: bit0 = instruction fetch, bit1 = LSU data.
  typedef logic [1:0] rice_core_bus_owner;

  localparam rice_core_bus_owner FETCH = 2'b01;
  localparam rice_core_bus_owner DATA  = 2'b10;

endpackage

// File: rtl/rice_core_bus_arbiter_if.sv
// Core memory bus: valid/ready request channel plus valid/ready response channel.
interface rice_bus_if #(
  parameter int unsigned XLEN = 32
) ();

  localparam int unsigned STRB_W = XLEN / 8;

  logic              req_valid;
  logic              req_ready;
  logic [XLEN-1:0]   req_addr;
  logic              req_write;
  logic [XLEN-1:0]   req_wdata;
  logic [STRB_W-1:0] req_strb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_error;

  modport master (
    output req_valid, req_addr, req_write, req_wdata, req_strb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_wdata, req_strb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );

endinterface

// File: rtl/rice_core_bus_arbiter_priority.sv
// Combinational owner selection between fetch and data requesters.
// RICE_CORE_BUS_ARBITER_ROUND_ROBIN_EN: the requester that did not own the last transaction wins a tie.
module rice_core_bus_arbiter_priority
  import rice_core_pkg::*;
(
  input  logic               inst_valid,
  input  logic               data_valid,
`ifdef RICE_CORE_BUS_ARBITER_ROUND_ROBIN_EN
  input  rice_core_bus_owner last_owner,
`endif
  output rice_core_bus_owner grant_c
);

  always_comb begin
    grant_c = '0;
    if (inst_valid && data_valid) begin
`ifdef RICE_CORE_BUS_ARBITER_ROUND_ROBIN_EN
      grant_c = (last_owner == DATA) ? FETCH : DATA;
`else
      grant_c = DATA;
`endif
    end else if (data_valid) begin
      grant_c = DATA;
    end else if (inst_valid) begin
      grant_c = FETCH;
    end
  end

endmodule

// File: rtl/rice_core_bus_arbiter.sv
// Shares one memory bus between fetch and LSU: one outstanding transaction, owner held until response.
// Optional macro RICE_CORE_BUS_ARBITER_ROUND_ROBIN_EN alternates tie priority via a last-owner register.
module rice_core_bus_arbiter
  import rice_core_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  rice_bus_if.slave        inst_bus_if,
  rice_bus_if.slave        data_bus_if,
  rice_bus_if.master       memory_bus_if,
  output logic             o_busy,
  output logic [1:0]       o_grant
);

  localparam int unsigned STRB_W = XLEN / 8;

  rice_core_bus_arbiter_state state_q, state_d;
  rice_core_bus_owner         grant_q, grant_d;
  rice_core_bus_owner         sel_grant_c;
  logic                       busy_q;
  logic                       req_fire_c;
  logic                       rsp_fire_c;

`ifdef RICE_CORE_BUS_ARBITER_ROUND_ROBIN_EN
  rice_core_bus_owner last_owner_q;

  // Remember who owned the last completed transaction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_owner_q <= FETCH;
    end else if (state_q == ST_RESPONSE && rsp_fire_c) begin
      last_owner_q <= grant_q;
    end
  end
`endif

  rice_core_bus_arbiter_priority u_priority (
    .inst_valid (inst_bus_if.req_valid),
    .data_valid (data_bus_if.req_valid),
`ifdef RICE_CORE_BUS_ARBITER_ROUND_ROBIN_EN
    .last_owner (last_owner_q),
`endif
    .grant_c    (sel_grant_c)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (i_enable && (inst_bus_if.req_valid || data_bus_if.req_valid)) begin
          grant_d = sel_grant_c;
          state_d = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        if (req_fire_c) begin
          state_d = ST_RESPONSE;
        end
      end
      ST_RESPONSE: begin
        if (rsp_fire_c) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Channel routing: only the owner is connected, and only in the matching phase.
  always_comb begin
    memory_bus_if.req_valid = 1'b0;
    memory_bus_if.req_addr  = XLEN'(0);
    memory_bus_if.req_write = 1'b0;
    memory_bus_if.req_wdata = XLEN'(0);
    memory_bus_if.req_strb  = STRB_W'(0);
    memory_bus_if.rsp_ready = 1'b0;
    inst_bus_if.req_ready   = 1'b0;
    inst_bus_if.rsp_valid   = 1'b0;
    inst_bus_if.rsp_rdata   = XLEN'(0);
    inst_bus_if.rsp_error   = 1'b0;
    data_bus_if.req_ready   = 1'b0;
    data_bus_if.rsp_valid   = 1'b0;
    data_bus_if.rsp_rdata   = XLEN'(0);
    data_bus_if.rsp_error   = 1'b0;
    req_fire_c              = 1'b0;
    rsp_fire_c              = 1'b0;

    if (state_q == ST_REQUEST) begin
      if (grant_q == DATA) begin
        memory_bus_if.req_valid = data_bus_if.req_valid;
        memory_bus_if.req_addr  = data_bus_if.req_addr;
        memory_bus_if.req_write = data_bus_if.req_write;
        memory_bus_if.req_wdata = data_bus_if.req_wdata;
        memory_bus_if.req_strb  = data_bus_if.req_strb;
        data_bus_if.req_ready   = memory_bus_if.req_ready;
        req_fire_c              = data_bus_if.req_valid && memory_bus_if.req_ready;
      end else if (grant_q == FETCH) begin
        memory_bus_if.req_valid = inst_bus_if.req_valid;
        memory_bus_if.req_addr  = inst_bus_if.req_addr;
        memory_bus_if.req_write = inst_bus_if.req_write;
        memory_bus_if.req_wdata = inst_bus_if.req_wdata;
        memory_bus_if.req_strb  = inst_bus_if.req_strb;
        inst_bus_if.req_ready   = memory_bus_if.req_ready;
        req_fire_c              = inst_bus_if.req_valid && memory_bus_if.req_ready;
      end
    end

    if (state_q == ST_RESPONSE) begin
      if (grant_q == DATA) begin
        data_bus_if.rsp_valid   = memory_bus_if.rsp_valid;
        data_bus_if.rsp_rdata   = memory_bus_if.rsp_rdata;
        data_bus_if.rsp_error   = memory_bus_if.rsp_error;
        memory_bus_if.rsp_ready = data_bus_if.rsp_ready;
        rsp_fire_c              = memory_bus_if.rsp_valid && data_bus_if.rsp_ready;
      end else if (grant_q == FETCH) begin
        inst_bus_if.rsp_valid   = memory_bus_if.rsp_valid;
        inst_bus_if.rsp_rdata   = memory_bus_if.rsp_rdata;
        inst_bus_if.rsp_error   = memory_bus_if.rsp_error;
        memory_bus_if.rsp_ready = inst_bus_if.rsp_ready;
        rsp_fire_c              = memory_bus_if.rsp_valid && inst_bus_if.rsp_ready;
      end
    end
  end

  assign o_busy  = busy_q;
  assign o_grant = grant_q;

endmodule

// File: tb/tb_rice_core_bus_arbiter.sv
// Directed bench for rice_core_bus_arbiter: grant order, stalls, enable gating and async reset.
module tb_rice_core_bus_arbiter;
  import rice_core_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_enable;
  logic       o_busy;
  logic [1:0] o_grant;
  int         checks = 0;
  int         errors = 0;

  rice_bus_if #(.XLEN(32)) inst_if ();
  rice_bus_if #(.XLEN(32)) data_if ();
  rice_bus_if #(.XLEN(32)) mem_if ();

  rice_core_bus_arbiter #(.XLEN(32)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_enable      (i_enable),
    .inst_bus_if   (inst_if),
    .data_bus_if   (data_if),
    .memory_bus_if (mem_if),
    .o_busy        (o_busy),
    .o_grant       (o_grant)
  );

  always #5 i_clk = ~i_clk;

  // An owner must hold its request until the downstream accepts it.
  a_fetch_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (o_grant == 2'b01 && inst_if.req_valid && !inst_if.req_ready) |=> inst_if.req_valid)
    else $error("FAIL fetch_valid_dropped_in_request");
  a_data_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (o_grant == 2'b10 && data_if.req_valid && !data_if.req_ready) |=> data_if.req_valid)
    else $error("FAIL data_valid_dropped_in_request");

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs;
    inst_if.req_valid = 1'b0; inst_if.req_addr = '0; inst_if.req_write = 1'b0;
    inst_if.req_wdata = '0;   inst_if.req_strb = '0; inst_if.rsp_ready = 1'b0;
    data_if.req_valid = 1'b0; data_if.req_addr = '0; data_if.req_write = 1'b0;
    data_if.req_wdata = '0;   data_if.req_strb = '0; data_if.rsp_ready = 1'b0;
    mem_if.req_ready  = 1'b0; mem_if.rsp_valid = 1'b0;
    mem_if.rsp_rdata  = '0;   mem_if.rsp_error = 1'b0;
  endtask

  // Stimulus only: from REQUEST, accept the request then return a one-cycle response.
  task automatic finish_txn(input logic is_data, input logic [31:0] rdata);
    mem_if.req_ready = 1'b1;
    step();
    mem_if.req_ready = 1'b0;
    if (is_data) begin data_if.req_valid = 1'b0; data_if.rsp_ready = 1'b1; end
    else         begin inst_if.req_valid = 1'b0; inst_if.rsp_ready = 1'b1; end
    mem_if.rsp_valid = 1'b1;
    mem_if.rsp_rdata = rdata;
    step();
    mem_if.rsp_valid = 1'b0;
    data_if.rsp_ready = 1'b0;
    inst_if.rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    i_enable = 1'b1;
    i_rst_n  = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_grant} !== 3'b000) begin
      errors++; $display("FAIL reset_busy_grant got %b want %b", {o_busy, o_grant}, 3'b000);
    end
    checks++;
    if ({mem_if.req_valid, mem_if.rsp_ready, inst_if.req_ready, data_if.req_ready,
         inst_if.rsp_valid, data_if.rsp_valid} !== 6'b0) begin
      errors++; $display("FAIL reset_valids got %b want 000000",
        {mem_if.req_valid, mem_if.rsp_ready, inst_if.req_ready, data_if.req_ready,
         inst_if.rsp_valid, data_if.rsp_valid});
    end
    checks++;
    if (mem_if.req_addr !== 32'h0 || mem_if.req_wdata !== 32'h0 || inst_if.rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_data got addr=%h wdata=%h rdata=%h want 0",
        mem_if.req_addr, mem_if.req_wdata, inst_if.rsp_rdata);
    end
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step();
    checks++;
    if ({o_busy, o_grant} !== 3'b000) begin
      errors++; $display("FAIL idle_after_reset got %b want 000", {o_busy, o_grant});
    end
  endtask

  task automatic test_single_fetch;
    inst_if.req_valid = 1'b1;
    inst_if.req_addr  = 32'h0000_0100;
    checks++;
    if (mem_if.req_valid !== 1'b0) begin
      errors++; $display("FAIL idle_no_forward got %b want 0", mem_if.req_valid);
    end
    step();
    checks++;
    if ({o_busy, o_grant} !== 3'b101) begin
      errors++; $display("FAIL fetch_grant got %b want 101", {o_busy, o_grant});
    end
    checks++;
    if (mem_if.req_valid !== 1'b1 || mem_if.req_addr !== 32'h0000_0100) begin
      errors++; $display("FAIL fetch_forward got v=%b a=%h want v=1 a=00000100",
        mem_if.req_valid, mem_if.req_addr);
    end
    mem_if.req_ready = 1'b1;
    #1;
    checks++;
    if ({inst_if.req_ready, data_if.req_ready} !== 2'b10) begin
      errors++; $display("FAIL fetch_ready_route got %b want 10", {inst_if.req_ready, data_if.req_ready});
    end
    step();
    mem_if.req_ready  = 1'b0;
    inst_if.req_valid = 1'b0;
    mem_if.rsp_valid  = 1'b1;
    mem_if.rsp_rdata  = 32'hDEAD_BEEF;
    inst_if.rsp_ready = 1'b1;
    #1;
    checks++;
    if (inst_if.rsp_valid !== 1'b1 || inst_if.rsp_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL fetch_response got v=%b d=%h want v=1 d=deadbeef",
        inst_if.rsp_valid, inst_if.rsp_rdata);
    end
    checks++;
    if ({o_grant, mem_if.req_valid, mem_if.rsp_ready, data_if.rsp_valid, data_if.req_ready} !== 6'b010100) begin
      errors++; $display("FAIL fetch_response_phase got %b want 010100",
        {o_grant, mem_if.req_valid, mem_if.rsp_ready, data_if.rsp_valid, data_if.req_ready});
    end
    step();
    mem_if.rsp_valid  = 1'b0;
    inst_if.rsp_ready = 1'b0;
    checks++;
    if ({o_busy, o_grant} !== 3'b000) begin
      errors++; $display("FAIL fetch_done_idle got %b want 000", {o_busy, o_grant});
    end
  endtask

  task automatic test_priority;
    logic [1:0] exp_first;
    logic [1:0] last;
    last = FETCH;
    for (int i = 0; i < 4; i++) begin
`ifdef RICE_CORE_BUS_ARBITER_ROUND_ROBIN_EN
      exp_first = (last == DATA) ? FETCH : DATA;
`else
      exp_first = DATA;
`endif
      inst_if.req_valid = 1'b1; inst_if.req_addr = 32'h1000 + 32'(i);
      data_if.req_valid = 1'b1; data_if.req_addr = 32'h2000 + 32'(i);
      step();
      checks++;
      if (o_grant !== exp_first) begin
        errors++; $display("FAIL tie_winner_%0d got %b want %b", i, o_grant, exp_first);
      end
      finish_txn(exp_first == DATA, 32'h1111_0000 + 32'(i));
      checks++;
      if (o_grant !== 2'b00) begin
        errors++; $display("FAIL tie_idle_%0d got %b want 00", i, o_grant);
      end
      step();
      checks++;
      if (o_grant !== ~exp_first || mem_if.req_valid !== 1'b1) begin
        errors++; $display("FAIL tie_loser_%0d got %b v=%b want %b v=1", i, o_grant, mem_if.req_valid, ~exp_first);
      end
      finish_txn(exp_first != DATA, 32'h2222_0000 + 32'(i));
      last = ~exp_first;
    end
  endtask

  task automatic test_stall;
    inst_if.req_valid = 1'b1;
    inst_if.req_addr  = 32'h0000_0200;
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({o_busy, o_grant, mem_if.req_valid, inst_if.req_ready} !== 5'b10110) begin
        errors++; $display("FAIL req_stall_%0d got %b want 10110", i,
          {o_busy, o_grant, mem_if.req_valid, inst_if.req_ready});
      end
      step();
    end
    mem_if.req_ready = 1'b1;
    step();
    mem_if.req_ready  = 1'b0;
    inst_if.req_valid = 1'b0;
    mem_if.rsp_valid  = 1'b1;
    mem_if.rsp_rdata  = 32'h5A5A_A5A5;
    mem_if.rsp_error  = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({o_busy, o_grant, mem_if.rsp_ready, inst_if.rsp_valid, inst_if.rsp_error} !== 6'b101011) begin
        errors++; $display("FAIL rsp_stall_%0d got %b want 101011", i,
          {o_busy, o_grant, mem_if.rsp_ready, inst_if.rsp_valid, inst_if.rsp_error});
      end
      step();
    end
    inst_if.rsp_ready = 1'b1;
    #1;
    checks++;
    if (mem_if.rsp_ready !== 1'b1 || inst_if.rsp_rdata !== 32'h5A5A_A5A5) begin
      errors++; $display("FAIL rsp_release got r=%b d=%h want r=1 d=5a5aa5a5",
        mem_if.rsp_ready, inst_if.rsp_rdata);
    end
    step();
    mem_if.rsp_valid  = 1'b0;
    mem_if.rsp_error  = 1'b0;
    inst_if.rsp_ready = 1'b0;
    checks++;
    if ({o_busy, o_grant} !== 3'b000) begin
      errors++; $display("FAIL stall_done_idle got %b want 000", {o_busy, o_grant});
    end
  endtask

  task automatic test_enable;
    data_if.req_valid = 1'b1;
    data_if.req_write = 1'b1;
    data_if.req_addr  = 32'h0000_0300;
    data_if.req_wdata = 32'hCAFE_F00D;
    data_if.req_strb  = 4'hF;
    step();
    checks++;
    if (o_grant !== 2'b10 || mem_if.req_write !== 1'b1 || mem_if.req_wdata !== 32'hCAFE_F00D ||
        mem_if.req_strb !== 4'hF) begin
      errors++; $display("FAIL write_forward got g=%b w=%b d=%h s=%h want g=10 w=1 d=cafef00d s=f",
        o_grant, mem_if.req_write, mem_if.req_wdata, mem_if.req_strb);
    end
    mem_if.req_ready = 1'b1;
    step();
    mem_if.req_ready  = 1'b0;
    data_if.req_valid = 1'b0;
    data_if.req_write = 1'b0;
    inst_if.req_valid = 1'b1;
    inst_if.req_addr  = 32'h0000_0400;
    i_enable          = 1'b0;
    mem_if.rsp_valid  = 1'b1;
    mem_if.rsp_rdata  = 32'h0;
    data_if.rsp_ready = 1'b1;
    #1;
    checks++;
    if ({data_if.rsp_valid, inst_if.rsp_valid, o_busy} !== 3'b101) begin
      errors++; $display("FAIL disabled_completion got %b want 101",
        {data_if.rsp_valid, inst_if.rsp_valid, o_busy});
    end
    step();
    mem_if.rsp_valid  = 1'b0;
    data_if.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({o_busy, o_grant, mem_if.req_valid} !== 4'b0000) begin
        errors++; $display("FAIL disabled_hold_%0d got %b want 0000", i, {o_busy, o_grant, mem_if.req_valid});
      end
      step();
    end
    i_enable = 1'b1;
    step();
    checks++;
    if (o_grant !== 2'b01 || mem_if.req_addr !== 32'h0000_0400) begin
      errors++; $display("FAIL reenable_grant got g=%b a=%h want g=01 a=00000400", o_grant, mem_if.req_addr);
    end
    finish_txn(1'b0, 32'h0);
  endtask

  task automatic test_reset_mid;
    inst_if.req_valid = 1'b1;
    inst_if.req_addr  = 32'h0000_0500;
    step();
    mem_if.req_ready = 1'b1;
    step();
    mem_if.req_ready  = 1'b0;
    inst_if.req_valid = 1'b0;
    mem_if.rsp_valid  = 1'b1;
    mem_if.rsp_rdata  = 32'h0BAD_0BAD;
    #1;
    checks++;
    if ({o_busy, inst_if.rsp_valid} !== 2'b11) begin
      errors++; $display("FAIL pre_reset_response got %b want 11", {o_busy, inst_if.rsp_valid});
    end
    #1;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_grant} !== 3'b000) begin
      errors++; $display("FAIL async_reset_state got %b want 000", {o_busy, o_grant});
    end
    checks++;
    if ({mem_if.req_valid, mem_if.rsp_ready, inst_if.rsp_valid, inst_if.rsp_rdata} !== 35'h0) begin
      errors++; $display("FAIL async_reset_outputs got %h want 0",
        {mem_if.req_valid, mem_if.rsp_ready, inst_if.rsp_valid, inst_if.rsp_rdata});
    end
    mem_if.rsp_valid = 1'b0;
    #2;
    i_rst_n = 1'b1;
    inst_if.req_valid = 1'b1;
    inst_if.req_addr  = 32'h0000_0600;
    step();
    checks++;
    if (o_grant !== 2'b01 || mem_if.req_addr !== 32'h0000_0600) begin
      errors++; $display("FAIL post_reset_grant got g=%b a=%h want g=01 a=00000600", o_grant, mem_if.req_addr);
    end
    mem_if.req_ready = 1'b1;
    step();
    mem_if.req_ready  = 1'b0;
    inst_if.req_valid = 1'b0;
    mem_if.rsp_valid  = 1'b1;
    mem_if.rsp_rdata  = 32'h1234_5678;
    inst_if.rsp_ready = 1'b1;
    #1;
    checks++;
    if (inst_if.rsp_valid !== 1'b1 || inst_if.rsp_rdata !== 32'h1234_5678) begin
      errors++; $display("FAIL post_reset_response got v=%b d=%h want v=1 d=12345678",
        inst_if.rsp_valid, inst_if.rsp_rdata);
    end
    step();
    mem_if.rsp_valid  = 1'b0;
    inst_if.rsp_ready = 1'b0;
    checks++;
    if ({o_busy, o_grant} !== 3'b000) begin
      errors++; $display("FAIL post_reset_idle got %b want 000", {o_busy, o_grant});
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_priority();
    test_stall();
    test_enable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
